// File: rtl/exc_commit_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : exc_commit_ctrl
// Purpose  : Writeback-stage commit controller. Takes one retiring
//            instruction per cycle (wb_ready is always 1), priority-encodes
//            its exception flags and the sampled interrupt, and issues one
//            registered exception, ERTN or CSR access per commit. On a
//            redirect it pulses flush and then swallows FLUSH_CYCLES cycles
//            of wrong-path commits.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            wb_*                  - retiring instruction (valid/ready)
//            int_signal            - interrupt request from the CSR file
//            csr_rdata             - CSR file read data (combinational on csr_num)
//            csr_num/we/wdata/wmask- CSR file request port (registered)
//            exc_*, ertn_signal    - exception / ERTN request (registered)
//            flush                 - fetch redirect pulse (registered)
//            rf_we, rf_wdata       - register-file write of the old CSR value
// Revision : 1.0 - initial release
// ============================================================================
module exc_commit_ctrl #(
    parameter int FLUSH_CYCLES = 3,
    parameter int CSR_NUM_W    = 14
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wb_valid,
    output logic                 wb_ready,
    input  logic [31:0]          wb_pc,
    input  logic [31:0]          wb_vaddr,
    input  logic [5:0]           wb_exc,
    input  logic                 wb_is_ertn,
    input  logic [1:0]           wb_csr_op,
    input  logic [CSR_NUM_W-1:0] wb_csr_num,
    input  logic [31:0]          wb_rd_val,
    input  logic [31:0]          wb_rj_val,
    input  logic                 int_signal,
    input  logic [31:0]          csr_rdata,
    output logic [CSR_NUM_W-1:0] csr_num,
    output logic                 csr_we,
    output logic [31:0]          csr_wdata,
    output logic [31:0]          csr_wmask,
    output logic                 exc_signal,
    output logic                 ertn_signal,
    output logic [5:0]           exc_ecode,
    output logic [8:0]           exc_esubcode,
    output logic [31:0]          exc_pc,
    output logic [31:0]          exc_vaddr,
    output logic                 flush,
    output logic                 rf_we,
    output logic [31:0]          rf_wdata
);

    localparam logic [0:0] c_st_idle    = 1'b0;
    localparam logic [0:0] c_st_drain   = 1'b1;
    localparam logic [3:0] c_drain_load = 4'(FLUSH_CYCLES);

    localparam logic [5:0] c_ecode_int  = 6'h00;
    localparam logic [5:0] c_ecode_adx  = 6'h08;   // ADEF and ADEM share this
    localparam logic [5:0] c_ecode_ale  = 6'h09;
    localparam logic [5:0] c_ecode_sys  = 6'h0B;
    localparam logic [5:0] c_ecode_brk  = 6'h0C;
    localparam logic [5:0] c_ecode_ine  = 6'h0D;

    localparam logic [1:0] c_op_none    = 2'b00;
    localparam logic [1:0] c_op_xchg    = 2'b11;

    logic [0:0]           r_state,        w_state;
    logic [3:0]           r_drain_cnt,    w_drain_cnt;
    logic [CSR_NUM_W-1:0] r_csr_num,      w_csr_num;
    logic                 r_csr_we,       w_csr_we;
    logic [31:0]          r_csr_wdata,    w_csr_wdata;
    logic [31:0]          r_csr_wmask,    w_csr_wmask;
    logic                 r_exc_signal,   w_exc_signal;
    logic                 r_ertn_signal,  w_ertn_signal;
    logic [5:0]           r_exc_ecode,    w_exc_ecode;
    logic [8:0]           r_exc_esubcode, w_exc_esubcode;
    logic [31:0]          r_exc_pc,       w_exc_pc;
    logic [31:0]          r_exc_vaddr,    w_exc_vaddr;
    logic                 r_flush,        w_flush;
    logic                 r_rf_we,        w_rf_we;

    logic       w_live;
    logic       w_take_int;
    logic       w_exc_any;
    logic [5:0] w_cause_ecode;
    logic [8:0] w_cause_esub;

    // A commit is honoured only outside the drain window.
    assign w_live     = wb_valid && (r_state == c_st_idle);
    // The interrupt block is exactly the cycle csr_we is high: the interrupt
    // line may not yet reflect a CSR write that is landing this cycle.
    assign w_take_int = w_live && int_signal && !r_csr_we;
    assign w_exc_any  = w_take_int || (|wb_exc);

    // Cause priority: INT, ADEF, INE, SYS, BRK, ALE, ADEM.
    always_comb begin
        w_cause_ecode = c_ecode_int;
        w_cause_esub  = 9'd0;
        if (w_take_int) begin
            w_cause_ecode = c_ecode_int;
        end else if (wb_exc[0]) begin
            w_cause_ecode = c_ecode_adx;
        end else if (wb_exc[1]) begin
            w_cause_ecode = c_ecode_ine;
        end else if (wb_exc[2]) begin
            w_cause_ecode = c_ecode_sys;
        end else if (wb_exc[3]) begin
            w_cause_ecode = c_ecode_brk;
        end else if (wb_exc[4]) begin
            w_cause_ecode = c_ecode_ale;
        end else if (wb_exc[5]) begin
            w_cause_ecode = c_ecode_adx;
            w_cause_esub  = 9'd1;
        end
    end

    always_comb begin
        w_state        = r_state;
        w_drain_cnt    = r_drain_cnt;
        w_csr_num      = r_csr_num;
        w_csr_we       = 1'b0;
        w_csr_wdata    = r_csr_wdata;
        w_csr_wmask    = r_csr_wmask;
        w_exc_signal   = 1'b0;
        w_ertn_signal  = 1'b0;
        w_exc_ecode    = r_exc_ecode;
        w_exc_esubcode = r_exc_esubcode;
        w_exc_pc       = r_exc_pc;
        w_exc_vaddr    = r_exc_vaddr;
        w_flush        = 1'b0;
        w_rf_we        = 1'b0;

        if (r_state == c_st_idle) begin
            if (w_live) begin
                if (w_exc_any) begin
                    // Exceptions suppress any CSR op or ERTN on the same commit.
                    w_exc_signal   = 1'b1;
                    w_flush        = 1'b1;
                    w_exc_ecode    = w_cause_ecode;
                    w_exc_esubcode = w_cause_esub;
                    w_exc_pc       = wb_pc;
                    w_exc_vaddr    = wb_vaddr;
                    w_state        = c_st_drain;
                    w_drain_cnt    = c_drain_load;
                end else if (wb_is_ertn) begin
                    w_ertn_signal  = 1'b1;
                    w_flush        = 1'b1;
                    w_state        = c_st_drain;
                    w_drain_cnt    = c_drain_load;
                end else if (wb_csr_op != c_op_none) begin
                    w_csr_num = wb_csr_num;
                    w_rf_we   = 1'b1;
                    if (wb_csr_op[1]) begin
                        w_csr_we    = 1'b1;
                        w_csr_wdata = wb_rd_val;
                        w_csr_wmask = (wb_csr_op == c_op_xchg) ? wb_rj_val : 32'hFFFF_FFFF;
                    end
                end
            end
        end else begin
            // Drain window: handshakes are absorbed with no effect.
            if (r_drain_cnt <= 4'd1) begin
                w_state     = c_st_idle;
                w_drain_cnt = 4'd0;
            end else begin
                w_drain_cnt = r_drain_cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= c_st_idle;
            r_drain_cnt    <= 4'd0;
            r_csr_num      <= '0;
            r_csr_we       <= 1'b0;
            r_csr_wdata    <= 32'd0;
            r_csr_wmask    <= 32'd0;
            r_exc_signal   <= 1'b0;
            r_ertn_signal  <= 1'b0;
            r_exc_ecode    <= 6'd0;
            r_exc_esubcode <= 9'd0;
            r_exc_pc       <= 32'd0;
            r_exc_vaddr    <= 32'd0;
            r_flush        <= 1'b0;
            r_rf_we        <= 1'b0;
        end else begin
            r_state        <= w_state;
            r_drain_cnt    <= w_drain_cnt;
            r_csr_num      <= w_csr_num;
            r_csr_we       <= w_csr_we;
            r_csr_wdata    <= w_csr_wdata;
            r_csr_wmask    <= w_csr_wmask;
            r_exc_signal   <= w_exc_signal;
            r_ertn_signal  <= w_ertn_signal;
            r_exc_ecode    <= w_exc_ecode;
            r_exc_esubcode <= w_exc_esubcode;
            r_exc_pc       <= w_exc_pc;
            r_exc_vaddr    <= w_exc_vaddr;
            r_flush        <= w_flush;
            r_rf_we        <= w_rf_we;
        end
    end

    assign wb_ready     = 1'b1;
    assign csr_num      = r_csr_num;
    assign csr_we       = r_csr_we;
    assign csr_wdata    = r_csr_wdata;
    assign csr_wmask    = r_csr_wmask;
    assign exc_signal   = r_exc_signal;
    assign ertn_signal  = r_ertn_signal;
    assign exc_ecode    = r_exc_ecode;
    assign exc_esubcode = r_exc_esubcode;
    assign exc_pc       = r_exc_pc;
    assign exc_vaddr    = r_exc_vaddr;
    assign flush        = r_flush;
    assign rf_we        = r_rf_we;
    // Pre-write CSR value, visible only while the register-file write is live.
    assign rf_wdata     = r_rf_we ? csr_rdata : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_exc_commit_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_exc_commit_ctrl
// Purpose  : Self-checking bench for exc_commit_ctrl: a table of directed
//            commits, hand-written multi-cycle sequences, and a randomized
//            run compared against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exc_commit_ctrl;

    localparam int FLUSH_CYCLES = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_pc, wb_vaddr, wb_rd_val, wb_rj_val;
    logic [5:0]  wb_exc;
    logic        wb_is_ertn;
    logic [1:0]  wb_csr_op;
    logic [13:0] wb_csr_num;
    logic        int_signal;
    logic [31:0] csr_rdata;
    logic [13:0] csr_num;
    logic        csr_we, exc_signal, ertn_signal, flush, rf_we;
    logic [31:0] csr_wdata, csr_wmask, exc_pc, exc_vaddr, rf_wdata;
    logic [5:0]  exc_ecode;
    logic [8:0]  exc_esubcode;

    always #5 clk = ~clk;

    exc_commit_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .CSR_NUM_W(14)) dut (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_pc(wb_pc), .wb_vaddr(wb_vaddr), .wb_exc(wb_exc), .wb_is_ertn(wb_is_ertn),
        .wb_csr_op(wb_csr_op), .wb_csr_num(wb_csr_num), .wb_rd_val(wb_rd_val),
        .wb_rj_val(wb_rj_val), .int_signal(int_signal), .csr_rdata(csr_rdata),
        .csr_num(csr_num), .csr_we(csr_we), .csr_wdata(csr_wdata), .csr_wmask(csr_wmask),
        .exc_signal(exc_signal), .ertn_signal(ertn_signal), .exc_ecode(exc_ecode),
        .exc_esubcode(exc_esubcode), .exc_pc(exc_pc), .exc_vaddr(exc_vaddr),
        .flush(flush), .rf_we(rf_we), .rf_wdata(rf_wdata)
    );

    // Simple CSR file stand-in: each register reads a distinct value.
    function automatic logic [31:0] csr_file_val(input logic [13:0] n);
        return 32'hC5A0_0000 ^ {18'd0, n};
    endfunction
    assign csr_rdata = csr_file_val(csr_num);

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Causes indexed in priority order: INT, ADEF, INE, SYS, BRK, ALE, ADEM.
    int cause_ecode [7] = '{0, 8, 13, 11, 12, 9, 8};
    int cause_esub  [7] = '{0, 0, 0, 0, 0, 0, 1};

    int          m_drain;
    logic        m_exc, m_ertn, m_we, m_flush, m_rfwe;
    logic [5:0]  m_ecode;
    logic [8:0]  m_sub;
    logic [31:0] m_pc, m_va, m_wd, m_wm;
    logic [13:0] m_num;

    task automatic model_edge();
        logic       last_write;
        logic [6:0] req;
        int         cause;
        if (reset) begin
            m_drain = 0; m_exc = 0; m_ertn = 0; m_we = 0; m_flush = 0; m_rfwe = 0;
            m_ecode = 0; m_sub = 0; m_pc = 0; m_va = 0; m_wd = 0; m_wm = 0; m_num = 0;
            return;
        end
        last_write = m_we;
        m_exc = 0; m_ertn = 0; m_we = 0; m_flush = 0; m_rfwe = 0;
        if (m_drain > 0) begin
            m_drain--;
        end else if (wb_valid) begin
            req   = {wb_exc, int_signal && !last_write};
            cause = -1;
            for (int i = 0; i < 7; i++)
                if (req[i] && cause < 0) cause = i;
            if (cause >= 0) begin
                m_exc = 1; m_flush = 1; m_drain = FLUSH_CYCLES;
                m_ecode = 6'(cause_ecode[cause]); m_sub = 9'(cause_esub[cause]);
                m_pc = wb_pc; m_va = wb_vaddr;
            end else if (wb_is_ertn) begin
                m_ertn = 1; m_flush = 1; m_drain = FLUSH_CYCLES;
            end else if (wb_csr_op != 2'b00) begin
                m_num  = wb_csr_num;
                m_rfwe = 1;
                if (wb_csr_op == 2'b10 || wb_csr_op == 2'b11) begin
                    m_we = 1;
                    m_wd = wb_rd_val;
                    m_wm = (wb_csr_op == 2'b11) ? wb_rj_val : 32'hFFFF_FFFF;
                end
            end
        end
    endtask

    task automatic cmp_model();
        chk("model_exc_signal",  32'(exc_signal),   32'(m_exc));
        chk("model_ertn_signal", 32'(ertn_signal),  32'(m_ertn));
        chk("model_csr_we",      32'(csr_we),       32'(m_we));
        chk("model_flush",       32'(flush),        32'(m_flush));
        chk("model_rf_we",       32'(rf_we),        32'(m_rfwe));
        chk("model_ecode",       32'(exc_ecode),    32'(m_ecode));
        chk("model_esubcode",    32'(exc_esubcode), 32'(m_sub));
        chk("model_exc_pc",      exc_pc,            m_pc);
        chk("model_exc_vaddr",   exc_vaddr,         m_va);
        chk("model_csr_num",     32'(csr_num),      32'(m_num));
        chk("model_csr_wdata",   csr_wdata,         m_wd);
        chk("model_csr_wmask",   csr_wmask,         m_wm);
        chk("model_rf_wdata",    rf_wdata,          m_rfwe ? csr_file_val(m_num) : 32'd0);
        chk("model_wb_ready",    32'(wb_ready),     32'd1);
    endtask

    // Advance one clock: model follows the edge, outputs sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        cmp_model();
    endtask

    task automatic set_in(input logic v, input logic [31:0] pc, input logic [31:0] va,
                          input logic [5:0] e, input logic er, input logic [1:0] op,
                          input logic [13:0] num, input logic [31:0] rd,
                          input logic [31:0] rj, input logic intr);
        wb_valid = v; wb_pc = pc; wb_vaddr = va; wb_exc = e; wb_is_ertn = er;
        wb_csr_op = op; wb_csr_num = num; wb_rd_val = rd; wb_rj_val = rj; int_signal = intr;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        valid;
        logic [5:0]  exc;
        logic        ertn;
        logic [1:0]  op;
        logic [13:0] num;
        logic [31:0] rd, rj;
        logic        intr;
        logic [4:0]  strobes;   // {exc_signal, ertn_signal, csr_we, flush, rf_we}
        logic [5:0]  ecode;
        logic [8:0]  sub;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [5:0] e, input logic er,
                                input logic [1:0] op, input logic [13:0] num,
                                input logic [31:0] rd, input logic [31:0] rj,
                                input logic intr, input logic [4:0] st,
                                input logic [5:0] ec, input logic [8:0] sb);
        vec_t r;
        r.valid = v; r.exc = e; r.ertn = er; r.op = op; r.num = num; r.rd = rd; r.rj = rj;
        r.intr = intr; r.strobes = st; r.ecode = ec; r.sub = sb;
        return r;
    endfunction

    localparam int NV = 30;
    vec_t vt [NV];

    initial begin
        vec_t v;
        // row: valid exc ertn op num rd rj int -> strobes ecode sub
        vt[0]  = mk(1, 6'h00, 0, 2'b10, 14'h30, 32'h1234,     32'h0,      0, 5'b00101, 0, 0);
        vt[1]  = mk(1, 6'h00, 0, 2'b11, 14'h31, 32'hABCDEF01, 32'hFF00,   0, 5'b00101, 0, 0);
        vt[2]  = mk(0, 6'h00, 0, 2'b00, 14'h0,  32'h0,        32'h0,      0, 5'b00000, 0, 0);
        vt[3]  = mk(1, 6'h00, 0, 2'b10, 14'h04, 32'h5,        32'h0,      0, 5'b00101, 0, 0);
        vt[4]  = mk(1, 6'h00, 0, 2'b01, 14'h05, 32'h0,        32'h0,      1, 5'b00001, 0, 0);
        vt[5]  = mk(1, 6'h00, 0, 2'b01, 14'h06, 32'h0,        32'h0,      1, 5'b10010, 6'h00, 0);
        vt[6]  = mk(1, 6'h04, 0, 2'b00, 14'h0,  32'h0,        32'h0,      0, 5'b00000, 0, 0);
        vt[7]  = mk(1, 6'h04, 0, 2'b00, 14'h0,  32'h0,        32'h0,      0, 5'b00000, 0, 0);
        vt[8]  = mk(1, 6'h04, 0, 2'b00, 14'h0,  32'h0,        32'h0,      1, 5'b00000, 0, 0);
        vt[9]  = mk(1, 6'h00, 1, 2'b00, 14'h0,  32'h0,        32'h0,      0, 5'b01010, 0, 0);
        vt[10] = mk(0, 6'h00, 0, 2'b00, 14'h0,  32'h0,        32'h0,      0, 5'b00000, 0, 0);
        vt[11] = mk(0, 6'h00, 0, 2'b00, 14'h0,  32'h0,        32'h0,      0, 5'b00000, 0, 0);
        vt[12] = mk(0, 6'h00, 0, 2'b00, 14'h0,  32'h0,        32'h0,      0, 5'b00000, 0, 0);
        vt[13] = mk(1, 6'h05, 0, 2'b10, 14'h07, 32'h0,        32'h0,      0, 5'b10010, 6'h08, 0);
        vt[14] = mk(1, 6'h04, 0, 2'b00, 14'h0,  32'h0,        32'h0,      0, 5'b00000, 0, 0);
        vt[15] = mk(1, 6'h04, 0, 2'b00, 14'h0,  32'h0,        32'h0,      0, 5'b00000, 0, 0);
        vt[16] = mk(1, 6'h04, 0, 2'b00, 14'h0,  32'h0,        32'h0,      0, 5'b00000, 0, 0);
        vt[17] = mk(1, 6'h00, 1, 2'b00, 14'h0,  32'h0,        32'h0,      0, 5'b01010, 0, 0);
        vt[18] = mk(0, 6'h00, 0, 2'b00, 14'h0,  32'h0,        32'h0,      0, 5'b00000, 0, 0);
        vt[19] = mk(0, 6'h00, 0, 2'b00, 14'h0,  32'h0,        32'h0,      0, 5'b00000, 0, 0);
        vt[20] = mk(0, 6'h00, 0, 2'b00, 14'h0,  32'h0,        32'h0,      0, 5'b00000, 0, 0);
        vt[21] = mk(1, 6'h0A, 1, 2'b00, 14'h0,  32'h0,        32'h0,      0, 5'b10010, 6'h0D, 0);
        vt[22] = mk(0, 6'h00, 0, 2'b00, 14'h0,  32'h0,        32'h0,      0, 5'b00000, 0, 0);
        vt[23] = mk(0, 6'h00, 0, 2'b00, 14'h0,  32'h0,        32'h0,      0, 5'b00000, 0, 0);
        vt[24] = mk(0, 6'h00, 0, 2'b00, 14'h0,  32'h0,        32'h0,      0, 5'b00000, 0, 0);
        vt[25] = mk(1, 6'h30, 0, 2'b00, 14'h0,  32'h0,        32'h0,      0, 5'b10010, 6'h09, 0);
        vt[26] = mk(0, 6'h00, 0, 2'b00, 14'h0,  32'h0,        32'h0,      0, 5'b00000, 0, 0);
        vt[27] = mk(0, 6'h00, 0, 2'b00, 14'h0,  32'h0,        32'h0,      0, 5'b00000, 0, 0);
        vt[28] = mk(1, 6'h08, 0, 2'b00, 14'h0,  32'h0,        32'h0,      0, 5'b00000, 0, 0);
        vt[29] = mk(1, 6'h00, 0, 2'b01, 14'h09, 32'h0,        32'h0,      0, 5'b00001, 0, 0);

        // ---------------- reset ----------------
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        chk("reset_strobes", 32'({exc_signal, ertn_signal, csr_we, flush, rf_we}), 32'd0);
        chk("reset_ecode",   32'({exc_ecode, exc_esubcode}), 32'd0);
        chk("reset_pc_va",   exc_pc | exc_vaddr, 32'd0);
        chk("reset_csr",     csr_wdata | csr_wmask | 32'(csr_num), 32'd0);
        chk("reset_rf_wdata", rf_wdata, 32'd0);
        reset = 1'b0;

        // ---------------- table ----------------
        for (int i = 0; i < NV; i++) begin
            v = vt[i];
            set_in(v.valid, 32'h1C00_0000 + 32'(i * 4), 32'h9000_0000 + 32'(i),
                   v.exc, v.ertn, v.op, v.num, v.rd, v.rj, v.intr);
            step();
            chk($sformatf("vec%0d_strobes", i),
                32'({exc_signal, ertn_signal, csr_we, flush, rf_we}), 32'(v.strobes));
            if (v.strobes[4]) begin
                chk($sformatf("vec%0d_ecode", i), 32'(exc_ecode), 32'(v.ecode));
                chk($sformatf("vec%0d_esub", i),  32'(exc_esubcode), 32'(v.sub));
            end
        end

        // ---------------- csrwr / csrxchg fields ----------------
        set_in(1, 32'h1C00_0200, 0, 0, 0, 2'b10, 14'h30, 32'h1234, 32'h0, 0);
        step();
        chk("csrwr_we",    32'(csr_we), 32'd1);
        chk("csrwr_wmask", csr_wmask, 32'hFFFF_FFFF);
        chk("csrwr_wdata", csr_wdata, 32'h0000_1234);
        chk("csrwr_num",   32'(csr_num), 32'h30);
        chk("csrwr_rf_wdata", rf_wdata, 32'hC5A0_0030);
        chk("csrwr_flush", 32'(flush), 32'd0);
        set_in(1, 32'h1C00_0204, 0, 0, 0, 2'b11, 14'h31, 32'hABCDEF01, 32'h0000_FF00, 0);
        step();
        chk("xchg_wmask", csr_wmask, 32'h0000_FF00);
        chk("xchg_wdata", csr_wdata, 32'hABCD_EF01);
        chk("xchg_we",    32'(csr_we), 32'd1);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        chk("xchg_we_one_cycle", 32'(csr_we), 32'd0);

        // ---------------- ADEF|SYS then drain, then ERTN ----------------
        set_in(1, 32'h1C00_0100, 32'h1, 6'h05, 0, 0, 0, 0, 0, 0);
        step();
        chk("adef_exc_pc", exc_pc, 32'h1C00_0100);
        chk("adef_ecode",  32'(exc_ecode), 32'h08);
        chk("adef_flush",  32'(flush), 32'd1);
        for (int k = 0; k < FLUSH_CYCLES; k++) begin
            set_in(1, 32'h1C00_0104 + 32'(k * 4), 0, 6'h04, 0, 0, 0, 0, 0, 0);
            step();
            chk($sformatf("drain%0d_quiet", k),
                32'({exc_signal, ertn_signal, csr_we, flush, rf_we}), 32'd0);
        end
        set_in(1, 32'h1C00_0110, 0, 0, 1, 0, 0, 0, 0, 0);
        step();
        chk("post_drain_ertn", 32'(ertn_signal), 32'd1);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (FLUSH_CYCLES) step();

        // ---------------- ADEM, then reset in the first drain cycle ----------------
        set_in(1, 32'h1C00_0300, 32'h8000_0003, 6'h20, 0, 0, 0, 0, 0, 0);
        step();
        chk("adem_ecode", 32'(exc_ecode), 32'h08);
        chk("adem_esub",  32'(exc_esubcode), 32'd1);
        chk("adem_vaddr", exc_vaddr, 32'h8000_0003);
        reset = 1'b1;
        set_in(1, 32'h1C00_0304, 0, 6'h04, 0, 0, 0, 0, 0, 0);
        step();
        chk("rst_drain_strobes", 32'({exc_signal, ertn_signal, csr_we, flush, rf_we}), 32'd0);
        chk("rst_drain_fields",  exc_vaddr | exc_pc | 32'(exc_ecode) | 32'(exc_esubcode), 32'd0);
        reset = 1'b0;
        set_in(1, 32'h1C00_0308, 0, 0, 0, 2'b10, 14'h44, 32'h77, 0, 0);
        step();
        chk("after_rst_commit", 32'(csr_we), 32'd1);

        // ---------------- randomized run against the model ----------------
        for (int n = 0; n < 600; n++) begin
            logic       er;
            logic [1:0] op;
            logic [5:0] e;
            reset = ($urandom_range(0, 99) < 2);
            e  = ($urandom_range(0, 99) < 25) ? 6'($urandom) : 6'd0;
            er = ($urandom_range(0, 99) < 10);
            op = er ? 2'b00 : 2'($urandom);
            set_in($urandom_range(0, 99) < 80, $urandom, $urandom, e, er, op,
                   14'($urandom_range(0, 15)), $urandom, $urandom,
                   $urandom_range(0, 99) < 30);
            step();
        end

        reset = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
